// File: rtl/serial_parallel_pkg.sv
// Shared state encoding, comma constant and counter sizing for the serial word aligner.
package serial_parallel_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] K28_5 = 8'hBC;

    // Bits needed to hold every value from 0 to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sp_comma_detector.sv
// Serial shift register exposing the current WIDTH-bit window (including the bit
// being sampled now) and a flag for when that window equals the comma symbol.
module sp_comma_detector
    import serial_parallel_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(K28_5)
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] window,
    output logic             comma_hit
);

    logic [WIDTH-2:0] sr_reg;

    assign window = {sr_reg, data_in};

    // Case equality keeps an X/Z sample from ever registering as a comma.
    assign comma_hit = (window === COMMA);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= window[WIDTH-2:0];
        end
    end

endmodule

// File: rtl/serial_parallel_align.sv
// Comma-aligned serial-to-parallel converter: hunts for COMMA, locks after LOCK_COUNT aligned commas,
// strobes WIDTH-bit words while locked. Define SERIAL_PARALLEL_COMMA_STRIP_EN to suppress aligned comma words.
module serial_parallel_align
    import serial_parallel_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(K28_5),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 2
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             word_valid,
    output logic             is_comma,
    output logic             locked
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = cnt_width(LOCK_COUNT);
    localparam int MW = cnt_width(LOSS_COUNT);
    localparam logic [PW-1:0] PHASE_LAST = PW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_MAX   = CW'(LOCK_COUNT);
    localparam logic [MW-1:0] LOSS_MAX   = MW'(LOSS_COUNT);
`ifdef SERIAL_PARALLEL_COMMA_STRIP_EN
    localparam bit STRIP_COMMAS = 1'b1;
`else
    localparam bit STRIP_COMMAS = 1'b0;
`endif

    logic [WIDTH-1:0] window;
    logic             comma_hit;

    state_t           state_reg, state_next;
    logic [PW-1:0]    phase_reg, phase_next;
    logic [CW-1:0]    comma_cnt_reg, comma_cnt_next, comma_inc;
    logic [MW-1:0]    mis_cnt_reg, mis_cnt_next, mis_inc;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic             word_valid_reg, word_valid_next;
    logic             is_comma_reg, is_comma_next;
    logic             locked_reg;
    logic             boundary;

    sp_comma_detector #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_detect (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .window    (window),
        .comma_hit (comma_hit)
    );

    assign boundary  = (phase_reg == PHASE_LAST);
    assign comma_inc = (comma_cnt_reg == LOCK_MAX) ? comma_cnt_reg : comma_cnt_reg + CW'(1);
    assign mis_inc   = (mis_cnt_reg == LOSS_MAX) ? mis_cnt_reg : mis_cnt_reg + MW'(1);

    always_comb begin
        state_next      = state_reg;
        phase_next      = boundary ? '0 : phase_reg + PW'(1);
        comma_cnt_next  = comma_cnt_reg;
        mis_cnt_next    = mis_cnt_reg;
        data_out_next   = data_out_reg;
        word_valid_next = 1'b0;
        is_comma_next   = is_comma_reg;
        unique case (state_reg)
            ST_HUNT: begin
                if (comma_hit) begin
                    phase_next     = '0;
                    comma_cnt_next = CW'(1);
                    state_next     = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (boundary) begin
                    if (comma_hit) begin
                        comma_cnt_next = comma_inc;
                        if (comma_inc == LOCK_MAX) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        comma_cnt_next = '0;
                        state_next     = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    if (comma_hit) begin
                        mis_cnt_next = '0;
                    end
                    if (!(comma_hit && STRIP_COMMAS)) begin
                        data_out_next   = window;
                        word_valid_next = 1'b1;
                        is_comma_next   = comma_hit;
                    end
                end else if (comma_hit) begin
                    // A comma off the word grid: realign onto it once enough have been seen.
                    if (mis_inc == LOSS_MAX) begin
                        state_next     = ST_ALIGN;
                        phase_next     = '0;
                        comma_cnt_next = CW'(1);
                        mis_cnt_next   = '0;
                    end else begin
                        mis_cnt_next = mis_inc;
                    end
                end
            end
            default: begin
                state_next = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_HUNT;
            phase_reg      <= '0;
            comma_cnt_reg  <= '0;
            mis_cnt_reg    <= '0;
            data_out_reg   <= '0;
            word_valid_reg <= 1'b0;
            is_comma_reg   <= 1'b0;
            locked_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            comma_cnt_reg  <= comma_cnt_next;
            mis_cnt_reg    <= mis_cnt_next;
            data_out_reg   <= data_out_next;
            word_valid_reg <= word_valid_next;
            is_comma_reg   <= is_comma_next;
            locked_reg     <= (state_reg == ST_LOCKED);
        end
    end

    assign data_out   = data_out_reg;
    assign word_valid = word_valid_reg;
    assign is_comma   = is_comma_reg;
    assign locked     = locked_reg;

endmodule

// File: tb/tb_serial_parallel_align.sv
// Bench for serial_parallel_align: directed scenarios plus random streams against a
// word-grid reference model (honours SERIAL_PARALLEL_COMMA_STRIP_EN when defined).
module tb_serial_parallel_align;

    localparam int W       = 8;
    localparam int COMMA_V = 'hBC;
    localparam int LOCK_N  = 4;
    localparam int LOSS_N  = 2;
`ifdef SERIAL_PARALLEL_COMMA_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic         clk_32f = 1'b0;
    logic         reset   = 1'b1;
    logic         data_in = 1'b0;
    logic [W-1:0] data_out;
    logic         word_valid;
    logic         is_comma;
    logic         locked;

    serial_parallel_align #(
        .WIDTH      (W),
        .COMMA      (8'hBC),
        .LOCK_COUNT (LOCK_N),
        .LOSS_COUNT (LOSS_N)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .word_valid (word_valid),
        .is_comma   (is_comma),
        .locked     (locked)
    );

    always #5 clk_32f = ~clk_32f;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 hunting, 1 aligning, 2 locked; word edges are anchor + k*W.
    int m_mode, m_anchor, m_cnt, m_mis, m_win, m_t;
    int exp_dout, exp_isc, exp_wv, exp_locked;
    int obs_words[$];
    bit saw_unlock;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_anchor = 0; m_cnt = 0; m_mis = 0; m_win = 0; m_t = 0;
        exp_dout = 0; exp_isc = 0; exp_wv = 0; exp_locked = 0;
    endtask

    task automatic model_step(input bit b);
        int  prev_mode;
        bit  hit;
        bit  on_grid;
        prev_mode = m_mode;
        m_win     = ((m_win << 1) | int'(b)) & 'hFF;
        m_t++;
        hit     = (m_win == COMMA_V);
        on_grid = (m_t > m_anchor) && (((m_t - m_anchor) % W) == 0);
        exp_wv  = 0;
        case (m_mode)
            0: if (hit) begin
                m_anchor = m_t; m_cnt = 1; m_mode = 1;
            end
            1: if (on_grid) begin
                if (hit) begin
                    m_cnt++;
                    if (m_cnt >= LOCK_N) m_mode = 2;
                end else begin
                    m_cnt = 0; m_mode = 0;
                end
            end
            default: if (on_grid) begin
                if (hit) m_mis = 0;
                if (!hit || !STRIP) begin
                    exp_wv = 1; exp_dout = m_win; exp_isc = int'(hit);
                end
            end else if (hit) begin
                m_mis++;
                if (m_mis >= LOSS_N) begin
                    m_mode = 1; m_anchor = m_t; m_cnt = 1; m_mis = 0;
                end
            end
        endcase
        exp_locked = (prev_mode == 2) ? 1 : 0;
    endtask

    task automatic send_bit(input bit b);
        data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        check_eq("word_valid", int'(word_valid), exp_wv);
        check_eq("locked", int'(locked), exp_locked);
        check_eq("data_out", int'(data_out), exp_dout);
        check_eq("is_comma", int'(is_comma), exp_isc);
        if (!locked) saw_unlock = 1'b1;
        if (word_valid) begin
            obs_words.push_back(int'(data_out));
            $display("t=%0t word=0x%02h is_comma=%0b", $time, data_out, is_comma);
        end
    endtask

    task automatic send_byte(input int v);
        for (int i = W - 1; i >= 0; i--) send_bit(bit'((v >> i) & 1));
    endtask

    task automatic send_commas(input int n);
        for (int i = 0; i < n; i++) send_byte(COMMA_V);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = 1'b0;
        @(posedge clk_32f);
        #1;
        model_reset();
        check_eq("rst_data_out", int'(data_out), 0);
        check_eq("rst_word_valid", int'(word_valid), 0);
        check_eq("rst_is_comma", int'(is_comma), 0);
        check_eq("rst_locked", int'(locked), 0);
        reset = 1'b0;
        obs_words.delete();
    endtask

    initial begin
        int exp_t1[$];
        int npre, nk, nw, v;

        // Scenario 1: lock on BCx4, stream data, mid-stream comma.
        do_reset();
        send_byte('hAA);
        send_commas(LOCK_N);
        check_eq("t1_lock_lag", int'(locked), 0);
        send_bit(1'b1);  // MSB of 0xBB
        check_eq("t1_lock_rise", int'(locked), 1);
        for (int i = W - 2; i >= 0; i--) send_bit(bit'(('hBB >> i) & 1));
        send_byte('hCC); send_byte('hDD); send_byte('hEE); send_byte('hBC);
        send_byte('hFF); send_byte('h00);
        exp_t1 = '{'hBB, 'hCC, 'hDD, 'hEE};
        if (!STRIP) exp_t1.push_back('hBC);
        exp_t1.push_back('hFF);
        exp_t1.push_back('h00);
        check_eq("t1_word_count", obs_words.size(), exp_t1.size());
        for (int i = 0; i < exp_t1.size() && i < obs_words.size(); i++)
            check_eq("t1_word", obs_words[i], exp_t1[i]);

        // Scenario 2: broken alignment returns to hunt, then relock.
        do_reset();
        send_commas(3);
        send_byte('h55);
        check_eq("t2_unlocked", int'(locked), 0);
        send_commas(LOCK_N);
        send_byte('h11);
        check_eq("t2_word_count", obs_words.size(), 1);
        if (obs_words.size() > 0) check_eq("t2_first_word", obs_words[0], 'h11);

        // Scenario 3: arbitrary 3-bit prefix shifts the word grid.
        do_reset();
        for (int i = 0; i < 3; i++) send_bit(bit'($urandom_range(0, 1)));
        send_commas(LOCK_N);
        send_byte('hA5); send_byte('h3C);
        check_eq("t3_word_count", obs_words.size(), 2);
        if (obs_words.size() == 2) begin
            check_eq("t3_word0", obs_words[0], 'hA5);
            check_eq("t3_word1", obs_words[1], 'h3C);
        end

        // Scenario 5: two commas at offset 3 force realign, three more relock.
        do_reset();
        send_commas(LOCK_N);
        send_byte('h12);
        check_eq("t5_locked_before", int'(locked), 1);
        saw_unlock = 1'b0;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        send_commas(2);
        send_commas(LOCK_N - 1);
        send_byte('h77);
        check_eq("t5_unlock_seen", int'(saw_unlock), 1);
        check_eq("t5_relocked", int'(locked), 1);
        check_eq("t5_last_word", obs_words[$], 'h77);

        // Scenario 6: asynchronous reset mid-word while locked.
        do_reset();
        send_commas(LOCK_N);
        send_byte('h3A);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check_eq("t6_locked_before", int'(locked), 1);
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("t6_async_data_out", int'(data_out), 0);
        check_eq("t6_async_word_valid", int'(word_valid), 0);
        check_eq("t6_async_is_comma", int'(is_comma), 0);
        check_eq("t6_async_locked", int'(locked), 0);
        #2;
        reset = 1'b0;
        obs_words.delete();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check_eq("t6_no_partial", obs_words.size(), 0);
        send_commas(LOCK_N);
        send_byte('hC3);
        check_eq("t6_relock_word", (obs_words.size() > 0) ? obs_words[$] : -1, 'hC3);

        // Random streams: offsets, lock lengths, data with commas, misaligned injections.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            npre = $urandom_range(0, 7);
            for (int i = 0; i < npre; i++) send_bit(bit'($urandom_range(0, 1)));
            nk = $urandom_range(3, 5);
            send_commas(nk);
            nw = $urandom_range(2, 8);
            for (int i = 0; i < nw; i++) begin
                v = ($urandom_range(0, 5) == 0) ? COMMA_V : int'($urandom_range(0, 255));
                send_byte(v);
            end
            if ($urandom_range(0, 3) == 0) begin
                npre = $urandom_range(1, 7);
                for (int i = 0; i < npre; i++) send_bit(bit'($urandom_range(0, 1)));
                send_commas($urandom_range(1, 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_parallel_align.md
Name: serial_parallel_align

Overview:
Parametrised successor to the fixed 8-bit serial-to-parallel converter in the PCIe PHY receive path. It takes a serial bit stream one bit per clk_32f cycle, hunts for a comma symbol (default K28.5, 0xBC) at any bit offset, and locks word alignment after LOCK_COUNT consecutive aligned commas. Once locked, it emits WIDTH-bit words with a one-cycle strobe. It drops back to hunting after repeated misaligned commas.

Parameters:
WIDTH, 8, word width in bits; valid range 4..16.
COMMA, 8'hBC, alignment symbol, WIDTH bits wide.
LOCK_COUNT, 4, consecutive aligned commas required to lock; minimum 1.
LOSS_COUNT, 2, misaligned commas seen while locked that force a realign; minimum 1.

Ports:
clk_32f  input  1  bit clock; one serial bit per rising edge
reset  input  1  asynchronous, active-high; clears all state
data_in  input  1  serial bit; the first bit of each word is the word MSB
data_out  output  WIDTH  last aligned word
word_valid  output  1  one-cycle strobe: data_out holds a new word
is_comma  output  1  qualifies word_valid; data_out equals COMMA
locked  output  1  high while in LOCKED state

Behaviour:
- Shift register: sr <= {sr[WIDTH-2:0], data_in} every edge. window = {sr[WIDTH-2:0], data_in}, the value that includes the bit being sampled now. All compares use window.
- Reset (async, high): sr=0, phase=0, comma_cnt=0, mis_cnt=0, state=HUNT. data_out=0, word_valid=0, is_comma=0, locked=0. Reset mid-operation discards any partial word; no strobe is issued for it.
- phase counts 0..WIDTH-1 and wraps. The boundary is the edge at which phase==WIDTH-1.
- HUNT:
  - On any edge where window==COMMA: phase<=0 (next bit is the MSB of a new word), comma_cnt<=1.
  - Go to ALIGN, or straight to LOCKED if LOCK_COUNT==1.
- ALIGN:
  - At a boundary with window==COMMA: comma_cnt++. When it reaches LOCK_COUNT, go to LOCKED.
  - At a boundary with window!=COMMA: go to HUNT, comma_cnt=0.
  - Commas at non-boundary positions are ignored.
- LOCKED:
  - locked=1, registered; it asserts on the edge after the locking comma's last bit.
  - The locking comma itself is never strobed. The first strobed word is the next full word.
  - At each boundary: data_out<=window, word_valid<=1 for one cycle, is_comma<=(window==COMMA).
  - An aligned comma also clears mis_cnt. Non-comma words leave mis_cnt unchanged.
  - At a non-boundary edge with window==COMMA: mis_cnt++.
  - When mis_cnt reaches LOSS_COUNT: go to ALIGN with phase<=0, comma_cnt<=1, mis_cnt<=0. locked and word_valid are 0 from the next edge.
- Latency: word_valid and data_out update on the edge that samples the word's LSB. Outputs are visible for the following cycle. word_valid is low at all other times.
- Widths: phase is $clog2(WIDTH) bits. comma_cnt and mis_cnt are wide enough to hold LOCK_COUNT and LOSS_COUNT, and saturate at their limits.
- Simultaneous events: a boundary and an aligned comma on the same edge is handled by the boundary rule. The misaligned rule only applies off-boundary.
- data_in X/Z is never treated as a comma.

Optional Feature:
SERIAL_PARALLEL_COMMA_STRIP_EN
- Defined: aligned comma words in LOCKED do not assert word_valid. data_out is not updated for them, and is_comma stays 0. mis_cnt is still cleared.
- Undefined: commas are delivered with is_comma=1.

Decomposition:
- Package serial_parallel_pkg:
  - state encoding localparams ST_HUNT, ST_ALIGN, ST_LOCKED;
  - K28_5 = 8'hBC;
  - a counter-width helper.
- Sub-module sp_comma_detector (parameters WIDTH, COMMA): holds the shift register and outputs window and comma_hit.
- serial_parallel_align holds the FSM, the counters and the output registers.

Test Plan:
1. Reset, then AA, BC×4, BB, CC, DD, EE, BC, FF, 00 (defaults, strip off):
   - locked rises one cycle after the 4th BC;
   - word_valid pulses every 8 cycles carrying BB, CC, DD, EE, BC(is_comma=1), FF, 00;
   - AA and the locking BCs are never strobed.
2. BC×3, 55, then BC×4, 11:
   - returns to HUNT after 55 with locked=0;
   - relocks; 11 is strobed as the first word.
3. Prefix of 3 arbitrary bits, then BC×4, A5, 3C: locks at the shifted offset; outputs A5 then 3C exactly.
4. Same as 1 with SERIAL_PARALLEL_COMMA_STRIP_EN defined: no strobe for the mid-stream BC; FF follows EE 16 cycles later.
5. Locked, inject a bitstream containing two BCs at offset 3 (LOSS_COUNT=2):
   - locked falls after the 2nd BC;
   - 3 further aligned BCs relock; the next data word is correct.
6. Assert reset for 3 ns mid-word while locked: all outputs 0 immediately without a clock edge; the partial word is not strobed; relock after BC×4.
